// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem address per cycle and pairs each
// returned word with its PC for decode, using a one-entry hold buffer across decode stalls.
module instruction_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instruction,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            if_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_valid_q, inflight_valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            hold_valid_q, hold_valid_d;

  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] sel_instr;
  logic [XLEN-1:0] sel_pc;
  logic            sel_valid;
  logic            out_valid;

  assign target_aligned = redirect_target & ~XLEN'(3);
  assign imem_addr      = redirect ? target_aligned : pc_q;

  // Redirect outranks stall so a squash never waits behind a blocked decode.
  always_comb begin
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    hold_instr_d     = hold_instr_q;
    hold_pc_d        = hold_pc_q;
    hold_valid_d     = hold_valid_q;

    if (redirect) begin
      hold_valid_d     = 1'b0;
      inflight_pc_d    = target_aligned;
      inflight_valid_d = 1'b1;
      pc_d             = target_aligned + XLEN'(4);
    end else if (stall) begin
      inflight_valid_d = 1'b0;
      if (!hold_valid_q && inflight_valid_q) begin
        hold_instr_d = imem_instruction;
        hold_pc_d    = inflight_pc_q;
        hold_valid_d = 1'b1;
      end
    end else begin
      inflight_pc_d    = pc_q;
      inflight_valid_d = 1'b1;
      pc_d             = pc_q + XLEN'(4);
      hold_valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      hold_instr_q     <= '0;
      hold_pc_q        <= '0;
      hold_valid_q     <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      hold_instr_q     <= hold_instr_d;
      hold_pc_q        <= hold_pc_d;
      hold_valid_q     <= hold_valid_d;
    end
  end

  // Invalid slots present zeros so decode never sees a stale word or PC.
  always_comb begin
    if (hold_valid_q) begin
      sel_instr = hold_instr_q;
      sel_pc    = hold_pc_q;
      sel_valid = 1'b1;
    end else begin
      sel_instr = imem_instruction;
      sel_pc    = inflight_pc_q;
      sel_valid = inflight_valid_q;
    end
    out_valid = sel_valid & ~redirect & ~reset;
  end

  assign if_valid    = out_valid;
  assign if_instr    = out_valid ? sel_instr : '0;
  assign if_pc       = out_valid ? sel_pc : '0;
  assign if_pc_plus4 = if_pc + XLEN'(4);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus randomized traffic checked
// against an in-order scoreboard of fetched PCs and a word-indexed memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC_MAIN = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_WRAP = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr, imem_instruction, if_instr, if_pc, if_pc_plus4;
  logic        if_valid;

  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] target2 = 32'h0;
  logic [31:0] imem_addr2, imem_instruction2, if_instr2, if_pc2, if_pc_plus4_2;
  logic        if_valid2;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC_MAIN)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr),
    .imem_instruction(imem_instruction), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_valid(if_valid)
  );

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC_WRAP)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall2), .redirect(redirect2),
    .redirect_target(target2), .imem_addr(imem_addr2),
    .imem_instruction(imem_instruction2), .if_instr(if_instr2), .if_pc(if_pc2),
    .if_pc_plus4(if_pc_plus4_2), .if_valid(if_valid2)
  );

  // mem[i] = i + 1 for word index i
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  always @(posedge clk) begin
    imem_instruction  <= memf(imem_addr);
    imem_instruction2 <= memf(imem_addr2);
  end

  // Scoreboard: PCs fetched but not yet consumed by decode, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] m_next = 32'h0;
  logic        m_known = 1'b0;
  logic        m_prev_issue = 1'b0;
  logic        m_prev_reset = 1'b0;
  logic        m_prev_stall = 1'b0;

  logic        o_valid = 1'b0, p_valid;
  logic [31:0] o_pc = 32'h0, o_instr = 32'h0, o_plus4, o_addr, p_pc, p_instr;
  logic        o2_valid;
  logic [31:0] o2_pc, o2_instr, o2_plus4, o2_addr;

  logic        e_addr_known, e_must_valid, e_zero, e_hold_same, e_has_front;
  logic [31:0] e_addr, e_front;

  task automatic drive_cycle(input logic st, input logic rd, input logic [31:0] tgt, input logic rs);
    logic [31:0] aligned;
    @(negedge clk);
    stall = st;
    redirect = rd;
    redirect_target = tgt;
    reset = rs;
    #1;
    p_valid = o_valid;
    p_pc = o_pc;
    p_instr = o_instr;
    o_valid = if_valid;
    o_pc = if_pc;
    o_instr = if_instr;
    o_plus4 = if_pc_plus4;
    o_addr = imem_addr;
    o2_valid = if_valid2;
    o2_pc = if_pc2;
    o2_instr = if_instr2;
    o2_plus4 = if_pc_plus4_2;
    o2_addr = imem_addr2;

    aligned = {tgt[31:2], 2'b00};
    e_addr_known = m_known;
    e_addr = rd ? aligned : m_next;
    e_must_valid = m_prev_issue && !rd && !rs;
    e_zero = rs || (m_prev_reset && !rd);
    e_hold_same = st && m_prev_stall && !rd && !rs;
    e_has_front = exp_q.size() > 0;
    e_front = e_has_front ? exp_q[0] : 32'h0;

    if (rs) begin
      exp_q.delete();
      m_next = RESET_PC_MAIN;
      m_known = 1'b1;
      m_prev_issue = 1'b0;
      m_prev_reset = 1'b1;
      m_prev_stall = 1'b0;
    end else if (rd) begin
      exp_q.delete();
      exp_q.push_back(aligned);
      m_next = aligned + 32'd4;
      m_prev_issue = 1'b1;
      m_prev_reset = 1'b0;
      m_prev_stall = 1'b0;
    end else if (st) begin
      m_prev_issue = 1'b0;
      m_prev_reset = 1'b0;
      m_prev_stall = 1'b1;
    end else begin
      if (o_valid && e_has_front) void'(exp_q.pop_front());
      exp_q.push_back(m_next);
      m_next = m_next + 32'd4;
      m_prev_issue = 1'b1;
      m_prev_reset = 1'b0;
      m_prev_stall = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
        fails++;
        $display("[TB] FAIL reset_outputs cycle %0d: got valid=%b pc=%h instr=%h, want 0/0/0", i, o_valid, o_pc, o_instr);
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] w_addr[3] = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [31:0] w_pc[3]   = '{32'h0, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] w_p4[3]   = '{32'h0, 32'h0, 32'h4};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (o_addr !== 32'(4 * i) || o_valid !== (i > 0)) begin
        fails++;
        $display("[TB] FAIL seq_addr_valid cycle %0d: got addr=%h valid=%b, want addr=%h valid=%b", i, o_addr, o_valid, 32'(4 * i), (i > 0));
      end
      if (i > 0) begin
        checks++;
        if (o_pc !== 32'(4 * (i - 1)) || o_instr !== 32'(i) || o_plus4 !== 32'(4 * i)) begin
          fails++;
          $display("[TB] FAIL seq_data cycle %0d: got pc=%h instr=%h p4=%h, want %h/%h/%h", i, o_pc, o_instr, o_plus4, 32'(4 * (i - 1)), 32'(i), 32'(4 * i));
        end
      end
      checks++;
      if (o2_addr !== w_addr[i] || o2_valid !== (i > 0)) begin
        fails++;
        $display("[TB] FAIL wrap_reset_addr cycle %0d: got addr=%h valid=%b, want addr=%h valid=%b", i, o2_addr, o2_valid, w_addr[i], (i > 0));
      end
      if (i > 0) begin
        checks++;
        if (o2_pc !== w_pc[i] || o2_plus4 !== w_p4[i] || o2_instr !== memf(w_pc[i])) begin
          fails++;
          $display("[TB] FAIL wrap_reset_data cycle %0d: got pc=%h p4=%h instr=%h, want %h/%h/%h", i, o2_pc, o2_plus4, o2_instr, w_pc[i], w_p4[i], memf(w_pc[i]));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic found;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i < 3, 1'b0, 32'h0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== 32'h3 || o_addr !== 32'hC) begin
        fails++;
        $display("[TB] FAIL stall_hold cycle %0d: got valid=%b pc=%h instr=%h addr=%h, want 1/8/3/c", i, o_valid, o_pc, o_instr, o_addr);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (o_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || o_pc !== 32'hC || o_instr !== 32'h4) begin
      fails++;
      $display("[TB] FAIL stall_release_next: got found=%b pc=%h instr=%h, want 1/c/4", found, o_pc, o_instr);
    end
  endtask

  task automatic test_redirect();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h10) begin
      fails++;
      $display("[TB] FAIL redir_pre: got valid=%b pc=%h, want 1/10", o_valid, o_pc);
    end
    drive_cycle(1'b0, 1'b1, 32'h40, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_addr !== 32'h40) begin
      fails++;
      $display("[TB] FAIL redir_squash: got valid=%b addr=%h, want 0/40", o_valid, o_addr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_plus4 !== 32'h44 || o_instr !== 32'h11 || o_addr !== 32'h44) begin
      fails++;
      $display("[TB] FAIL redir_target: got valid=%b pc=%h p4=%h instr=%h addr=%h, want 1/40/44/11/44", o_valid, o_pc, o_plus4, o_instr, o_addr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h44 || o_instr !== 32'h12) begin
      fails++;
      $display("[TB] FAIL redir_follow: got valid=%b pc=%h instr=%h, want 1/44/12", o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h48 || o_instr !== 32'h13) begin
        fails++;
        $display("[TB] FAIL rs_hold cycle %0d: got valid=%b pc=%h instr=%h, want 1/48/13", i, o_valid, o_pc, o_instr);
      end
    end
    drive_cycle(1'b1, 1'b1, 32'h100, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_addr !== 32'h100) begin
      fails++;
      $display("[TB] FAIL rs_squash: got valid=%b addr=%h, want 0/100", o_valid, o_addr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== 32'h41) begin
      fails++;
      $display("[TB] FAIL rs_target: got valid=%b pc=%h instr=%h, want 1/100/41", o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_align_wrap();
    drive_cycle(1'b0, 1'b1, 32'h43, 1'b0);
    checks++;
    if (o_addr !== 32'h40 || o_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL align_addr: got addr=%h valid=%b, want 40/0", o_addr, o_valid);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_pc !== 32'h40 || o_instr !== 32'h11 || o_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL align_pc: got pc=%h instr=%h valid=%b, want 40/11/1", o_pc, o_instr, o_valid);
    end
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (o_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("[TB] FAIL wrap_redir_addr: got addr=%h, want fffffffc", o_addr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_pc !== 32'hFFFF_FFFC || o_plus4 !== 32'h0 || o_instr !== memf(32'hFFFF_FFFC) || o_addr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL wrap_last: got pc=%h p4=%h instr=%h addr=%h, want fffffffc/0/%h/0", o_pc, o_plus4, o_instr, o_addr, memf(32'hFFFF_FFFC));
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_pc !== 32'h0 || o_plus4 !== 32'h4 || o_instr !== 32'h1 || o_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_zero: got pc=%h p4=%h instr=%h valid=%b, want 0/4/1/1", o_pc, o_plus4, o_instr, o_valid);
    end
  endtask

  task automatic test_reset_midstall();
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h4) begin
      fails++;
      $display("[TB] FAIL rst_stall_pre: got valid=%b pc=%h, want 1/4", o_valid, o_pc);
    end
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL rst_stall_during: got valid=%b pc=%h instr=%h, want 0/0/0", o_valid, o_pc, o_instr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_addr !== RESET_PC_MAIN) begin
      fails++;
      $display("[TB] FAIL rst_stall_after: got valid=%b addr=%h, want 0/%h", o_valid, o_addr, RESET_PC_MAIN);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== RESET_PC_MAIN || o_instr !== memf(RESET_PC_MAIN)) begin
      fails++;
      $display("[TB] FAIL rst_stall_restart: got valid=%b pc=%h instr=%h, want 1/%h/%h", o_valid, o_pc, o_instr, RESET_PC_MAIN, memf(RESET_PC_MAIN));
    end
  endtask

  task automatic test_random();
    logic        st, rd, rs;
    logic [31:0] tgt;
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(99) < 2);
      rd = ($urandom_range(99) < 10);
      st = ($urandom_range(99) < 30);
      tgt = $urandom;
      if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      drive_cycle(st, rd, tgt, rs);
      if (e_addr_known) begin
        checks++;
        if (o_addr !== e_addr) begin
          fails++;
          $display("[TB] FAIL rand_addr n=%0d: got %h, want %h", n, o_addr, e_addr);
        end
      end
      if (e_must_valid) begin
        checks++;
        if (o_valid !== 1'b1) begin
          fails++;
          $display("[TB] FAIL rand_throughput n=%0d: got valid=%b, want 1", n, o_valid);
        end
      end
      if (rd || rs) begin
        checks++;
        if (o_valid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL rand_squash n=%0d: got valid=%b, want 0", n, o_valid);
        end
      end
      if (e_zero) begin
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
          fails++;
          $display("[TB] FAIL rand_reset_out n=%0d: got valid=%b pc=%h instr=%h, want 0/0/0", n, o_valid, o_pc, o_instr);
        end
      end
      if (o_valid === 1'b1) begin
        checks++;
        if (!e_has_front || o_pc !== e_front || o_instr !== memf(e_front) || o_plus4 !== e_front + 32'd4) begin
          fails++;
          $display("[TB] FAIL rand_order n=%0d: got pc=%h instr=%h p4=%h, want pc=%h (pending=%b)", n, o_pc, o_instr, o_plus4, e_front, e_has_front);
        end
      end
      if (e_hold_same) begin
        checks++;
        if (o_valid !== p_valid || o_pc !== p_pc || o_instr !== p_instr) begin
          fails++;
          $display("[TB] FAIL rand_stall_const n=%0d: got %b/%h/%h, want %b/%h/%h", n, o_valid, o_pc, o_instr, p_valid, p_pc, p_instr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_align_wrap();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
